io_hs_buffer: RTL and testbench
===============================

Name: io_hs_buffer

Overview:
- Parametrised buffered I/O handshake unit for the accumulator processor family.
- Replaces the processor's direct single-byte input_bus/output_bus handshake with an RX FIFO and a TX FIFO, each with a 4-phase device handshake.
- Processor side sees FIFO status, first-word-fall-through read data, and sticky error flags.
- Sits between the external device pins and the processor MDR input mux / ACC output path.

Parameters:
- DATA_W, 8, width of input_bus, output_bus and FIFO entries.
- ADDR_W, 2, FIFO pointer width; DEPTH = 2**ADDR_W entries per FIFO (default 4).

Ports:
- g_clk  in  1  global clock; all state updates on rising edge.
- g_clr  in  1  reset, synchronous, active-high.
- input_bus  in  DATA_W  device data into RX side.
- in_dev_hs  in  1  device data-ready request.
- in_dev_ack  out  1  unit has captured the input word.
- output_bus  out  DATA_W  registered data to the output device.
- out_req  out  1  output_bus is valid.
- out_dev_hs  in  1  output device ready to receive.
- out_dev_ack  in  1  output device has taken the word.
- rx_rd  in  1  processor pop strobe.
- rx_data  out  DATA_W  RX head word, FWFT; 0 when empty.
- rx_empty  out  1  RX FIFO empty flag.
- rx_full  out  1  RX FIFO full flag.
- rx_count  out  ADDR_W+1  number of RX entries.
- tx_wr  in  1  processor push strobe.
- tx_data  in  DATA_W  word pushed on tx_wr.
- tx_empty  out  1  TX FIFO empty flag.
- tx_full  out  1  TX FIFO full flag.
- tx_count  out  ADDR_W+1  number of TX entries.
- err_clr  in  1  clears sticky error flags.
- rx_udf  out  1  sticky: rx_rd issued while empty.
- tx_ovf  out  1  sticky: tx_wr issued while full.

Behaviour:
- Reset: g_clr high at an edge drives all outputs to 0 except rx_empty=1 and tx_empty=1. It clears pointers, counts, FIFO contents, error flags, and both FSMs to IDLE. Reset mid-handshake aborts the handshake; ack/req drop the next cycle.
- Full/empty decisions use the count at the start of the cycle (pre-edge).
- Counts saturate only by construction: no push when full, no pop when empty. Pointers wrap modulo DEPTH.
- RX FSM states:
  - R_IDLE: if in_dev_hs=1 and rx_full=0, push input_bus at this edge, set in_dev_ack=1 and go to R_ACK. If rx_full=1, wait; in_dev_ack stays 0 and no capture occurs.
  - R_ACK: in_dev_ack held 1 until a cycle with in_dev_hs=0, then in_dev_ack=0 and return to R_IDLE. One word per hs pulse.
  - in_dev_ack is registered: high the cycle after the capturing edge.
- RX read:
  - rx_data = mem[rd_ptr] combinationally.
  - rx_rd=1 with rx_empty=0 pops at the edge.
  - rx_rd with rx_empty=1 is ignored and sets rx_udf.
  - Push and pop in the same cycle with a non-empty FIFO: both occur, count unchanged.
  - When full, a pop is allowed but the push waits one cycle because the full check is pre-edge.
- TX write:
  - tx_wr=1 with tx_full=0 stores tx_data.
  - tx_wr with tx_full=1 drops the word and sets tx_ovf, even if a pop occurs in the same cycle.
- TX FSM states:
  - T_IDLE: if tx_empty=0 and out_dev_hs=1, load output_bus with the head word, pop it, set out_req=1 and go to T_REQ.
  - T_REQ: when out_dev_ack=1, clear out_req and go to T_WAIT.
  - T_WAIT: when out_dev_ack=0, return to T_IDLE.
  - output_bus holds its last value outside T_REQ.
- Latency:
  - Input capture to rx_empty=0: 1 cycle.
  - tx_wr on an empty FIFO with out_dev_hs=1 to out_req=1: 2 cycles (store, then load).
  - Minimum TX handshake: 3 cycles per word.
- err_clr clears both sticky flags. If a new error occurs in the same cycle, set wins.

Test Plan:
- Reset then idle: outputs 0, rx_empty=1, tx_empty=1, counts 0. Apply g_clr for 1 cycle mid-R_ACK → in_dev_ack=0 next cycle.
- RX sequence: device sends 0x11, 0x22, 0x33, 0x44 via 4-phase handshake (DEPTH=4) → rx_full=1, rx_count=4. A fifth hs is held with no ack. One rx_rd returns 0x11 and the fifth word 0x55 is then captured.
- RX underflow: rx_rd on an empty FIFO → rx_udf=1, count stays 0. err_clr → rx_udf=0.
- TX sequence: push 0xA5, 0x5A with out_dev_hs=1 → out_req rises with output_bus=0xA5. After ack high/low, 0x5A follows. tx_empty=1 at the end.
- TX overflow: out_dev_hs=0, push 5 words → tx_full=1, tx_ovf=1, fifth word absent from the drained sequence.
- Simultaneous ops: rx push and rx_rd in the same cycle at count 2 → count stays 2 and data order is preserved. Wrap-around after 10 pushes/pops at DEPTH=4 returns words in order.

Source files
------------

// File: rtl/io_hs_buffer_if.sv
// Handshake and processor-side bundle for io_hs_buffer: device pins, RX/TX
// FIFO access, status counts and sticky error flags.
interface io_hs_buffer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic [DATA_W-1:0] input_bus;
    logic              in_dev_hs;
    logic              in_dev_ack;
    logic [DATA_W-1:0] output_bus;
    logic              out_req;
    logic              out_dev_hs;
    logic              out_dev_ack;
    logic              rx_rd;
    logic [DATA_W-1:0] rx_data;
    logic              rx_empty;
    logic              rx_full;
    logic [ADDR_W:0]   rx_count;
    logic              tx_wr;
    logic [DATA_W-1:0] tx_data;
    logic              tx_empty;
    logic              tx_full;
    logic [ADDR_W:0]   tx_count;
    logic              err_clr;
    logic              rx_udf;
    logic              tx_ovf;

    modport slave (
        input  input_bus, in_dev_hs, out_dev_hs, out_dev_ack,
        input  rx_rd, tx_wr, tx_data, err_clr,
        output in_dev_ack, output_bus, out_req,
        output rx_data, rx_empty, rx_full, rx_count,
        output tx_empty, tx_full, tx_count, rx_udf, tx_ovf
    );

    modport master (
        output input_bus, in_dev_hs, out_dev_hs, out_dev_ack,
        output rx_rd, tx_wr, tx_data, err_clr,
        input  in_dev_ack, output_bus, out_req,
        input  rx_data, rx_empty, rx_full, rx_count,
        input  tx_empty, tx_full, tx_count, rx_udf, tx_ovf
    );
endinterface

// File: rtl/io_hs_buffer.sv
// Buffered I/O handshake unit: RX FIFO filled by a 4-phase input device, TX FIFO
// drained by a 4-phase output device, FWFT read port and sticky error flags.
module io_hs_buffer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic            g_clk,
    input  logic            g_clr,
    io_hs_buffer_if.slave   hs
);
    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ZERO_CNT = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1'b1);
    localparam logic [ADDR_W-1:0] ONE_PTR = ADDR_W'(1'b1);

    typedef enum logic [0:0] {R_IDLE = 1'b0, R_ACK = 1'b1} rx_state_t;
    typedef enum logic [1:0] {T_IDLE = 2'd0, T_REQ = 2'd1, T_WAIT = 2'd2} tx_state_t;

    logic [DATA_W-1:0] r_rx_mem [DEPTH];
    logic [ADDR_W-1:0] r_rx_wp;
    logic [ADDR_W-1:0] r_rx_rp;
    logic [ADDR_W:0]   r_rx_cnt;
    rx_state_t         r_rx_state;
    logic              r_in_dev_ack;

    logic [DATA_W-1:0] r_tx_mem [DEPTH];
    logic [ADDR_W-1:0] r_tx_wp;
    logic [ADDR_W-1:0] r_tx_rp;
    logic [ADDR_W:0]   r_tx_cnt;
    tx_state_t         r_tx_state;
    logic              r_out_req;
    logic [DATA_W-1:0] r_output_bus;

    logic r_rx_udf;
    logic r_tx_ovf;

    logic w_rx_empty, w_rx_full, w_rx_push, w_rx_pop;
    logic w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;

    // All full/empty decisions look at the count held before this edge.
    assign w_rx_empty = (r_rx_cnt == ZERO_CNT);
    assign w_rx_full  = (r_rx_cnt == FULL_CNT);
    assign w_tx_empty = (r_tx_cnt == ZERO_CNT);
    assign w_tx_full  = (r_tx_cnt == FULL_CNT);

    assign w_rx_push = (r_rx_state == R_IDLE) && hs.in_dev_hs && !w_rx_full;
    assign w_rx_pop  = hs.rx_rd && !w_rx_empty;
    assign w_tx_push = hs.tx_wr && !w_tx_full;
    assign w_tx_pop  = (r_tx_state == T_IDLE) && !w_tx_empty && hs.out_dev_hs;

    assign hs.in_dev_ack = r_in_dev_ack;
    assign hs.output_bus = r_output_bus;
    assign hs.out_req    = r_out_req;
    assign hs.rx_data    = w_rx_empty ? {DATA_W{1'b0}} : r_rx_mem[r_rx_rp];
    assign hs.rx_empty   = w_rx_empty;
    assign hs.rx_full    = w_rx_full;
    assign hs.rx_count   = r_rx_cnt;
    assign hs.tx_empty   = w_tx_empty;
    assign hs.tx_full    = w_tx_full;
    assign hs.tx_count   = r_tx_cnt;
    assign hs.rx_udf     = r_rx_udf;
    assign hs.tx_ovf     = r_tx_ovf;

    // RX FIFO storage, pointers and occupancy.
    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            for (int i = 0; i < DEPTH; i++) r_rx_mem[i] <= {DATA_W{1'b0}};
            r_rx_wp  <= {ADDR_W{1'b0}};
            r_rx_rp  <= {ADDR_W{1'b0}};
            r_rx_cnt <= ZERO_CNT;
        end else begin
            if (w_rx_push) begin
                r_rx_mem[r_rx_wp] <= hs.input_bus;
                r_rx_wp           <= r_rx_wp + ONE_PTR;
            end
            if (w_rx_pop) begin
                r_rx_rp <= r_rx_rp + ONE_PTR;
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + ONE_CNT;
                2'b01:   r_rx_cnt <= r_rx_cnt - ONE_CNT;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    // Input device handshake: one capture per hs pulse, ack held until hs drops.
    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            r_rx_state   <= R_IDLE;
            r_in_dev_ack <= 1'b0;
        end else begin
            case (r_rx_state)
                R_IDLE: begin
                    if (w_rx_push) begin
                        r_in_dev_ack <= 1'b1;
                        r_rx_state   <= R_ACK;
                    end
                end
                R_ACK: begin
                    if (!hs.in_dev_hs) begin
                        r_in_dev_ack <= 1'b0;
                        r_rx_state   <= R_IDLE;
                    end
                end
                default: begin
                    r_in_dev_ack <= 1'b0;
                    r_rx_state   <= R_IDLE;
                end
            endcase
        end
    end

    // TX FIFO storage, pointers and occupancy.
    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            for (int i = 0; i < DEPTH; i++) r_tx_mem[i] <= {DATA_W{1'b0}};
            r_tx_wp  <= {ADDR_W{1'b0}};
            r_tx_rp  <= {ADDR_W{1'b0}};
            r_tx_cnt <= ZERO_CNT;
        end else begin
            if (w_tx_push) begin
                r_tx_mem[r_tx_wp] <= hs.tx_data;
                r_tx_wp           <= r_tx_wp + ONE_PTR;
            end
            if (w_tx_pop) begin
                r_tx_rp <= r_tx_rp + ONE_PTR;
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + ONE_CNT;
                2'b01:   r_tx_cnt <= r_tx_cnt - ONE_CNT;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // Output device handshake: load head word, hold req until ack, wait for ack release.
    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            r_tx_state   <= T_IDLE;
            r_out_req    <= 1'b0;
            r_output_bus <= {DATA_W{1'b0}};
        end else begin
            case (r_tx_state)
                T_IDLE: begin
                    if (w_tx_pop) begin
                        r_output_bus <= r_tx_mem[r_tx_rp];
                        r_out_req    <= 1'b1;
                        r_tx_state   <= T_REQ;
                    end
                end
                T_REQ: begin
                    if (hs.out_dev_ack) begin
                        r_out_req  <= 1'b0;
                        r_tx_state <= T_WAIT;
                    end
                end
                T_WAIT: begin
                    if (!hs.out_dev_ack) begin
                        r_tx_state <= T_IDLE;
                    end
                end
                default: begin
                    r_out_req  <= 1'b0;
                    r_tx_state <= T_IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a fresh error beats err_clr in the same cycle.
    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            r_rx_udf <= 1'b0;
            r_tx_ovf <= 1'b0;
        end else begin
            if (hs.rx_rd && w_rx_empty) begin
                r_rx_udf <= 1'b1;
            end else if (hs.err_clr) begin
                r_rx_udf <= 1'b0;
            end
            if (hs.tx_wr && w_tx_full) begin
                r_tx_ovf <= 1'b1;
            end else if (hs.err_clr) begin
                r_tx_ovf <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_io_hs_buffer.sv
// Directed self-checking bench for io_hs_buffer (DATA_W=8, DEPTH=4).
module tb_io_hs_buffer;
    logic g_clk = 1'b0;
    logic g_clr;
    int   n_checks = 0;
    int   n_fail   = 0;

    io_hs_buffer_if #(.DATA_W(8), .ADDR_W(2)) bus ();

    io_hs_buffer #(.DATA_W(8), .ADDR_W(2)) dut (
        .g_clk (g_clk),
        .g_clr (g_clr),
        .hs    (bus.slave)
    );

    always #5 g_clk = ~g_clk;

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    // Full 4-phase input transfer of one byte; bounded waits on ack edges.
    task automatic rx_send(input logic [7:0] d);
        int n;
        bus.input_bus = d;
        bus.in_dev_hs = 1'b1;
        n = 0;
        while (bus.in_dev_ack !== 1'b1 && n < 10) begin tick(); n++; end
        n_checks++;
        if (bus.in_dev_ack !== 1'b1) begin n_fail++; $display("FAIL rx_send_ack_rise: got %b expected 1 for %h", bus.in_dev_ack, d); end
        bus.in_dev_hs = 1'b0;
        n = 0;
        while (bus.in_dev_ack !== 1'b0 && n < 10) begin tick(); n++; end
        n_checks++;
        if (bus.in_dev_ack !== 1'b0) begin n_fail++; $display("FAIL rx_send_ack_fall: got %b expected 0", bus.in_dev_ack); end
    endtask

    task automatic test_reset();
        g_clr = 1'b1;
        bus.input_bus = 8'h00; bus.in_dev_hs = 1'b0; bus.out_dev_hs = 1'b0; bus.out_dev_ack = 1'b0;
        bus.rx_rd = 1'b0; bus.tx_wr = 1'b0; bus.tx_data = 8'h00; bus.err_clr = 1'b0;
        tick(); tick();
        g_clr = 1'b0;
        tick();
        n_checks++;
        if ({bus.in_dev_ack, bus.out_req, bus.rx_full, bus.tx_full, bus.rx_udf, bus.tx_ovf, bus.rx_empty, bus.tx_empty} !== 8'b0000_0011) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00000011", {bus.in_dev_ack, bus.out_req, bus.rx_full, bus.tx_full, bus.rx_udf, bus.tx_ovf, bus.rx_empty, bus.tx_empty});
        end
        n_checks++;
        if ({bus.output_bus, bus.rx_data, bus.rx_count, bus.tx_count} !== 22'h0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", {bus.output_bus, bus.rx_data, bus.rx_count, bus.tx_count});
        end
        // Reset in the middle of an input handshake.
        bus.input_bus = 8'h77; bus.in_dev_hs = 1'b1;
        tick();
        n_checks++;
        if (bus.in_dev_ack !== 1'b1) begin n_fail++; $display("FAIL reset_mid_ack_up: got %b expected 1", bus.in_dev_ack); end
        g_clr = 1'b1; bus.in_dev_hs = 1'b0;
        tick();
        n_checks++;
        if ({bus.in_dev_ack, bus.rx_count} !== 4'b0000) begin n_fail++; $display("FAIL reset_mid_ack_drop: got %b expected 0000", {bus.in_dev_ack, bus.rx_count}); end
        g_clr = 1'b0;
        tick();
    endtask

    task automatic test_rx_fill();
        logic [7:0] exp_q [4];
        exp_q = '{8'h22, 8'h33, 8'h44, 8'h55};
        rx_send(8'h11); rx_send(8'h22); rx_send(8'h33); rx_send(8'h44);
        n_checks++;
        if ({bus.rx_full, bus.rx_count, bus.rx_data} !== {1'b1, 3'd4, 8'h11}) begin
            n_fail++; $display("FAIL rx_fill_full: got full=%b cnt=%0d data=%h expected 1 4 11", bus.rx_full, bus.rx_count, bus.rx_data);
        end
        bus.input_bus = 8'h55; bus.in_dev_hs = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if ({bus.in_dev_ack, bus.rx_count} !== {1'b0, 3'd4}) begin
            n_fail++; $display("FAIL rx_fill_held: got ack=%b cnt=%0d expected 0 4", bus.in_dev_ack, bus.rx_count);
        end
        bus.rx_rd = 1'b1;
        tick();
        bus.rx_rd = 1'b0;
        n_checks++;
        if ({bus.in_dev_ack, bus.rx_count, bus.rx_data} !== {1'b0, 3'd3, 8'h22}) begin
            n_fail++; $display("FAIL rx_pop_when_full: got ack=%b cnt=%0d data=%h expected 0 3 22", bus.in_dev_ack, bus.rx_count, bus.rx_data);
        end
        tick();
        n_checks++;
        if ({bus.in_dev_ack, bus.rx_count} !== {1'b1, 3'd4}) begin
            n_fail++; $display("FAIL rx_fifth_capture: got ack=%b cnt=%0d expected 1 4", bus.in_dev_ack, bus.rx_count);
        end
        bus.in_dev_hs = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.rx_data !== exp_q[i]) begin n_fail++; $display("FAIL rx_drain[%0d]: got %h expected %h", i, bus.rx_data, exp_q[i]); end
            bus.rx_rd = 1'b1;
            tick();
        end
        bus.rx_rd = 1'b0;
        n_checks++;
        if ({bus.rx_empty, bus.rx_data, bus.rx_udf} !== {1'b1, 8'h00, 1'b0}) begin
            n_fail++; $display("FAIL rx_drained: got empty=%b data=%h udf=%b expected 1 00 0", bus.rx_empty, bus.rx_data, bus.rx_udf);
        end
    endtask

    task automatic test_rx_underflow();
        bus.rx_rd = 1'b1;
        tick();
        bus.rx_rd = 1'b0;
        n_checks++;
        if ({bus.rx_udf, bus.rx_count} !== {1'b1, 3'd0}) begin
            n_fail++; $display("FAIL rx_udf_set: got udf=%b cnt=%0d expected 1 0", bus.rx_udf, bus.rx_count);
        end
        tick();
        n_checks++;
        if (bus.rx_udf !== 1'b1) begin n_fail++; $display("FAIL rx_udf_sticky: got %b expected 1", bus.rx_udf); end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        n_checks++;
        if (bus.rx_udf !== 1'b0) begin n_fail++; $display("FAIL rx_udf_clear: got %b expected 0", bus.rx_udf); end
        // Error and clear together: the error must win.
        bus.err_clr = 1'b1; bus.rx_rd = 1'b1;
        tick();
        bus.rx_rd = 1'b0;
        n_checks++;
        if (bus.rx_udf !== 1'b1) begin n_fail++; $display("FAIL rx_udf_set_wins: got %b expected 1", bus.rx_udf); end
        tick();
        bus.err_clr = 1'b0;
        n_checks++;
        if (bus.rx_udf !== 1'b0) begin n_fail++; $display("FAIL rx_udf_reclear: got %b expected 0", bus.rx_udf); end
    endtask

    task automatic test_tx_sequence();
        bus.out_dev_hs = 1'b1;
        bus.tx_wr = 1'b1; bus.tx_data = 8'hA5;
        tick();
        n_checks++;
        if ({bus.out_req, bus.tx_count} !== {1'b0, 3'd1}) begin
            n_fail++; $display("FAIL tx_store: got req=%b cnt=%0d expected 0 1", bus.out_req, bus.tx_count);
        end
        bus.tx_data = 8'h5A;
        tick();
        bus.tx_wr = 1'b0;
        n_checks++;
        if ({bus.out_req, bus.output_bus, bus.tx_count} !== {1'b1, 8'hA5, 3'd1}) begin
            n_fail++; $display("FAIL tx_first_req: got req=%b bus=%h cnt=%0d expected 1 a5 1", bus.out_req, bus.output_bus, bus.tx_count);
        end
        bus.out_dev_ack = 1'b1;
        tick();
        n_checks++;
        if ({bus.out_req, bus.output_bus} !== {1'b0, 8'hA5}) begin
            n_fail++; $display("FAIL tx_ack_drop: got req=%b bus=%h expected 0 a5", bus.out_req, bus.output_bus);
        end
        bus.out_dev_ack = 1'b0;
        tick();
        n_checks++;
        if (bus.out_req !== 1'b0) begin n_fail++; $display("FAIL tx_wait_idle: got %b expected 0", bus.out_req); end
        tick();
        n_checks++;
        if ({bus.out_req, bus.output_bus, bus.tx_empty} !== {1'b1, 8'h5A, 1'b1}) begin
            n_fail++; $display("FAIL tx_second_req: got req=%b bus=%h empty=%b expected 1 5a 1", bus.out_req, bus.output_bus, bus.tx_empty);
        end
        bus.out_dev_ack = 1'b1;
        tick();
        bus.out_dev_ack = 1'b0;
        tick();
        bus.out_dev_hs = 1'b0;
        tick();
        n_checks++;
        if ({bus.out_req, bus.tx_empty, bus.output_bus} !== {1'b0, 1'b1, 8'h5A}) begin
            n_fail++; $display("FAIL tx_done: got req=%b empty=%b bus=%h expected 0 1 5a", bus.out_req, bus.tx_empty, bus.output_bus);
        end
    endtask

    task automatic test_tx_overflow();
        logic [7:0] words [5];
        int n;
        words = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
        bus.out_dev_hs = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.tx_wr = 1'b1; bus.tx_data = words[i];
            tick();
        end
        bus.tx_wr = 1'b0;
        n_checks++;
        if ({bus.tx_full, bus.tx_count, bus.tx_ovf} !== {1'b1, 3'd4, 1'b1}) begin
            n_fail++; $display("FAIL tx_ovf_full: got full=%b cnt=%0d ovf=%b expected 1 4 1", bus.tx_full, bus.tx_count, bus.tx_ovf);
        end
        bus.out_dev_hs = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (bus.out_req !== 1'b1 && n < 10) begin tick(); n++; end
            n_checks++;
            if ({bus.out_req, bus.output_bus} !== {1'b1, words[i]}) begin
                n_fail++; $display("FAIL tx_ovf_drain[%0d]: got req=%b bus=%h expected 1 %h", i, bus.out_req, bus.output_bus, words[i]);
            end
            bus.out_dev_ack = 1'b1;
            tick();
            bus.out_dev_ack = 1'b0;
            tick();
        end
        tick(); tick(); tick();
        n_checks++;
        if ({bus.out_req, bus.tx_empty, bus.output_bus} !== {1'b0, 1'b1, 8'hB4}) begin
            n_fail++; $display("FAIL tx_ovf_no_fifth: got req=%b empty=%b bus=%h expected 0 1 b4", bus.out_req, bus.tx_empty, bus.output_bus);
        end
        bus.out_dev_hs = 1'b0;
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        n_checks++;
        if (bus.tx_ovf !== 1'b0) begin n_fail++; $display("FAIL tx_ovf_clear: got %b expected 0", bus.tx_ovf); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] w;
        rx_send(8'h01); rx_send(8'h02);
        bus.input_bus = 8'h03; bus.in_dev_hs = 1'b1; bus.rx_rd = 1'b1;
        tick();
        bus.rx_rd = 1'b0;
        n_checks++;
        if ({bus.rx_count, bus.rx_data, bus.in_dev_ack} !== {3'd2, 8'h02, 1'b1}) begin
            n_fail++; $display("FAIL sim_push_pop: got cnt=%0d data=%h ack=%b expected 2 02 1", bus.rx_count, bus.rx_data, bus.in_dev_ack);
        end
        bus.in_dev_hs = 1'b0;
        tick();
        bus.rx_rd = 1'b1;
        tick();
        bus.rx_rd = 1'b0;
        n_checks++;
        if ({bus.rx_count, bus.rx_data} !== {3'd1, 8'h03}) begin
            n_fail++; $display("FAIL sim_order: got cnt=%0d data=%h expected 1 03", bus.rx_count, bus.rx_data);
        end
        bus.rx_rd = 1'b1;
        tick();
        bus.rx_rd = 1'b0;
        // Ten single-word round trips walk both pointers around the ring.
        for (int i = 0; i < 10; i++) begin
            w = 8'hC0 + 8'(i);
            rx_send(w);
            n_checks++;
            if ({bus.rx_count, bus.rx_data} !== {3'd1, w}) begin
                n_fail++; $display("FAIL wrap[%0d]: got cnt=%0d data=%h expected 1 %h", i, bus.rx_count, bus.rx_data, w);
            end
            bus.rx_rd = 1'b1;
            tick();
            bus.rx_rd = 1'b0;
        end
        n_checks++;
        if ({bus.rx_empty, bus.rx_count, bus.rx_udf} !== {1'b1, 3'd0, 1'b0}) begin
            n_fail++; $display("FAIL wrap_end: got empty=%b cnt=%0d udf=%b expected 1 0 0", bus.rx_empty, bus.rx_count, bus.rx_udf);
        end
    endtask

    initial begin
        test_reset();
        test_rx_fill();
        test_rx_underflow();
        test_tx_sequence();
        test_tx_overflow();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
